aud_dac_serializer: RTL and testbench

- Downstream consumer of the 2 kHz IIR lowpass output. Sits between the filter and the codec DAC data pin.
- Captures each filtered 16-bit sample on the filter's i_valid strobe and buffers it in a small FIFO.
- Serializes samples MSB-first onto the DAC data line in I2S format, framed by the codec-supplied BCLK/DACLRCK.
- Mono path: the same sample is sent in the left and right slots of one LRCK period.

---
 rtl/aud_dac_serializer.sv | 162 ++++++++++++++++
 tb/tb_aud_dac_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/aud_dac_serializer.sv
// rtl/aud_dac_serializer.sv - I2S mono DAC serializer with sample FIFO
//
// Purpose: buffers filtered samples in a small FIFO and shifts each one
// MSB-first onto the codec DAC data pin. The codec supplies BCLK and DACLRCK.
// The same word goes out in both the left and the right slot of an LRCK period.
//
// Ports:
//   clk          system clock, at least 4x the BCLK frequency
//   i_rst_n      synchronous active-low reset
//   i_valid      one-cycle strobe qualifying i_sample
//   i_sample     signed filtered sample
//   i_en         serializer enable
//   i_bclk       codec bit clock (asynchronous)
//   i_daclrck    codec LR clock, 0 = left, 1 = right (asynchronous)
//   o_dac_data   serial DAC data
//   o_level      FIFO occupancy
//   o_full       FIFO full
//   o_overflow   pulse: sample dropped because the FIFO was full
//   o_underflow  pulse: left-slot pop found the FIFO empty
module aud_dac_serializer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  input  logic [DATA_W-1:0]             i_sample,
  input  logic                          i_en,
  input  logic                          i_bclk,
  input  logic                          i_daclrck,
  output logic                          o_dac_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_full,
  output logic                          o_overflow,
  output logic                          o_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, SHIFT, PAD} state_t;

  state_t              state_q, state_d;
  logic [2:0]          bclk_sync, lrck_sync;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       count_q, count_d;
  logic [DATA_W-1:0]   held, shreg;
  logic [CW-1:0]       bit_cnt;
  logic                dout;
  logic                overflow_q, underflow_q, full_q;

  logic bclk_fall, lrck_edge, lrck_left;
  logic fifo_empty, fifo_full_now;
  logic pop_req, pop, push;
  logic load, shift, zero;

  // [0] and [1] form the two-flop synchronizer; [2] is the edge-detect history.
  assign bclk_fall = bclk_sync[2] & ~bclk_sync[1];
  assign lrck_edge = lrck_sync[2] ^ lrck_sync[1];
  assign lrck_left = ~lrck_sync[1];

  assign fifo_empty    = (count_q == '0);
  assign fifo_full_now = (count_q == LW'(FIFO_DEPTH));
  assign pop           = pop_req & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push          = i_valid & (~fifo_full_now | pop);
  assign count_d       = count_q + LW'(push) - LW'(pop);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    zero    = 1'b0;
    pop_req = 1'b0;
    if (!i_en) begin
      state_d = IDLE;
      zero    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          zero    = 1'b1;
          state_d = WAIT_FRAME;
        end
        WAIT_FRAME, PAD: begin
          if (lrck_edge) begin
            load    = 1'b1;
            pop_req = lrck_left;
            state_d = SHIFT;
          end else if (state_q == PAD && bclk_fall) begin
            zero = 1'b1;
          end
        end
        SHIFT: begin
          // A new LRCK edge wins over a coincident BCLK fall: that fall is
          // the I2S one-bit delay slot, so the MSB goes out on the next fall.
          if (lrck_edge) begin
            load    = 1'b1;
            pop_req = lrck_left;
          end else if (bclk_fall) begin
            shift = 1'b1;
            if (bit_cnt == CW'(DATA_W - 1)) state_d = PAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_sample;
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      bclk_sync   <= '0;
      lrck_sync   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      held        <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      dout        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bclk_sync   <= {bclk_sync[1:0], i_bclk};
      lrck_sync   <= {lrck_sync[1:0], i_daclrck};
      count_q     <= count_d;
      full_q      <= (count_d == LW'(FIFO_DEPTH));
      overflow_q  <= i_valid & fifo_full_now & ~pop;
      underflow_q <= pop_req & fifo_empty;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        held   <= mem[rd_ptr];
      end
      if (load) begin
        // On an empty pop the previous held word is repeated.
        shreg   <= pop ? mem[rd_ptr] : held;
        bit_cnt <= '0;
      end else if (shift) begin
        dout    <= shreg[DATA_W-1];
        shreg   <= {shreg[DATA_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (zero) dout <= 1'b0;
    end
  end

  assign o_dac_data  = dout;
  assign o_level     = count_q;
  assign o_full      = full_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

endmodule

// File: tb/tb_aud_dac_serializer.sv
// tb/tb_aud_dac_serializer.sv - directed self-checking bench for aud_dac_serializer
module tb_aud_dac_serializer;

  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [15:0] i_sample;
  logic        i_en;
  logic        i_bclk;
  logic        i_daclrck;
  logic        o_dac_data;
  logic [2:0]  o_level;
  logic        o_full;
  logic        o_overflow;
  logic        o_underflow;

  int checks   = 0;
  int failures = 0;
  int ov_cnt   = 0;
  int un_cnt   = 0;

  aud_dac_serializer #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .i_sample   (i_sample),
    .i_en       (i_en),
    .i_bclk     (i_bclk),
    .i_daclrck  (i_daclrck),
    .o_dac_data (o_dac_data),
    .o_level    (o_level),
    .o_full     (o_full),
    .o_overflow (o_overflow),
    .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_overflow)  ov_cnt++;
    if (o_underflow) un_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_sample(input logic [15:0] v);
    @(negedge clk);
    i_valid  = 1'b1;
    i_sample = v;
    @(negedge clk);
    i_valid  = 1'b0;
  endtask

  // One BCLK period starting with a falling edge; returns dout just before the next fall.
  task automatic bclk_period(output logic b);
    i_bclk = 1'b0;
    repeat (4) @(negedge clk);
    i_bclk = 1'b1;
    repeat (4) @(negedge clk);
    b = o_dac_data;
  endtask

  // One 32-BCLK slot; LRCK changes with the first BCLK fall. An optional push
  // is timed to coincide with the clk edge that acts on the LRCK edge.
  task automatic run_slot(input logic lr, input logic push_en, input logic [15:0] pv,
                          output logic [15:0] word, output logic pad_or);
    logic b;
    i_bclk    = 1'b0;
    i_daclrck = lr;
    @(negedge clk);
    @(negedge clk);
    if (push_en) begin
      i_valid  = 1'b1;
      i_sample = pv;
    end
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    i_bclk = 1'b1;
    repeat (4) @(negedge clk);
    word   = '0;
    pad_or = 1'b0;
    for (int i = 1; i < 32; i++) begin
      bclk_period(b);
      if (i <= 16) word = {word[14:0], b};
      else         pad_or = pad_or | b;
    end
  endtask

  initial begin
    logic [15:0] w;
    logic        p, b;
    logic [5:0]  first6;
    logic        rest_or;
    int          ov_base, un_base;
    logic [15:0] exp_order [5];

    i_rst_n   = 1'b0;
    i_valid   = 1'b0;
    i_sample  = '0;
    i_en      = 1'b0;
    i_bclk    = 1'b0;
    i_daclrck = 1'b0;

    // Reset with the codec clocks toggling.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i_bclk    = ~i_bclk;
      i_daclrck = ~i_daclrck;
    end
    @(negedge clk);
    check("rst_dout", o_dac_data, 0);
    check("rst_level", o_level, 0);
    check("rst_full", o_full, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_unf", o_underflow, 0);

    i_bclk    = 1'b1;
    i_daclrck = 1'b1;
    i_rst_n   = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_dout", o_dac_data, 0);

    // Basic frame.
    push_sample(16'hA5C3);
    @(negedge clk);
    check("basic_level_push", o_level, 1);
    i_en = 1'b1;
    repeat (3) @(negedge clk);
    run_slot(1'b0, 1'b0, '0, w, p);
    check("basic_left_word", w, 16'hA5C3);
    check("basic_left_pad", p, 0);
    check("basic_level_pop", o_level, 0);
    run_slot(1'b1, 1'b0, '0, w, p);
    check("basic_right_word", w, 16'hA5C3);
    check("basic_right_pad", p, 0);
    check("basic_no_unf", un_cnt, 0);

    // Underflow: one sample, then a left frame with nothing queued.
    push_sample(16'h7FFF);
    run_slot(1'b0, 1'b0, '0, w, p);
    check("unf_left1", w, 16'h7FFF);
    run_slot(1'b1, 1'b0, '0, w, p);
    check("unf_right1", w, 16'h7FFF);
    check("unf_none_yet", un_cnt, 0);
    run_slot(1'b0, 1'b0, '0, w, p);
    check("unf_left2", w, 16'h7FFF);
    check("unf_pulse", un_cnt, 1);
    run_slot(1'b1, 1'b0, '0, w, p);
    check("unf_right2", w, 16'h7FFF);

    // FIFO full / overflow while disabled.
    @(negedge clk);
    i_en = 1'b0;
    @(negedge clk);
    check("dis_dout", o_dac_data, 0);
    ov_base = ov_cnt;
    for (int i = 1; i <= 5; i++) push_sample(16'(i));
    @(negedge clk);
    check("full_level", o_level, 4);
    check("full_flag", o_full, 1);
    check("full_ovf_once", ov_cnt - ov_base, 1);

    // Simultaneous push/pop at full on the first left edge, then drain.
    exp_order[0] = 16'd1;
    exp_order[1] = 16'd2;
    exp_order[2] = 16'd3;
    exp_order[3] = 16'd4;
    exp_order[4] = 16'd6;
    i_en = 1'b1;
    repeat (3) @(negedge clk);
    ov_base = ov_cnt;
    un_base = un_cnt;
    for (int k = 0; k < 5; k++) begin
      run_slot(1'b0, k == 0, 16'd6, w, p);
      check($sformatf("order_left%0d", k), w, exp_order[k]);
      if (k == 0) begin
        check("pushpop_level", o_level, 4);
        check("pushpop_full", o_full, 1);
        check("pushpop_no_ovf", ov_cnt - ov_base, 0);
      end
      run_slot(1'b1, 1'b0, '0, w, p);
      check($sformatf("order_right%0d", k), w, exp_order[k]);
    end
    check("drain_level", o_level, 0);
    check("drain_no_unf", un_cnt - un_base, 0);

    // Mid-frame disable.
    push_sample(16'hFFFF);
    push_sample(16'h1234);
    i_bclk    = 1'b0;
    i_daclrck = 1'b0;
    repeat (4) @(negedge clk);
    i_bclk = 1'b1;
    repeat (4) @(negedge clk);
    first6 = '0;
    for (int i = 1; i <= 6; i++) begin
      bclk_period(b);
      first6 = {first6[4:0], b};
    end
    check("mid_first6", first6, 6'h3F);
    i_en = 1'b0;
    @(negedge clk);
    check("mid_dis_dout", o_dac_data, 0);
    check("mid_dis_level", o_level, 1);
    rest_or = 1'b0;
    for (int i = 7; i < 32; i++) begin
      if (i == 10) i_en = 1'b1;
      bclk_period(b);
      rest_or = rest_or | b;
    end
    check("mid_rest_zero", rest_or, 0);
    check("mid_level_kept", o_level, 1);
    run_slot(1'b1, 1'b0, '0, w, p);
    check("mid_resume_word", w, 16'hFFFF);
    check("mid_resume_pad", p, 0);
    run_slot(1'b0, 1'b0, '0, w, p);
    check("mid_next_word", w, 16'h1234);
    check("mid_level_end", o_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
